// File: rtl/ps2_pkg.sv
// Shared constants and the prefix FSM state type for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam int PS2_BYTE_W = 8;

  localparam logic [PS2_BYTE_W-1:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [PS2_BYTE_W-1:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_BASE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } ps2_state_t;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational scan-code set 2 to ASCII table (lower-case letters, digits,
// space, enter, backspace). Unmapped codes return 0.
module ps2_ascii_rom
  import ps2_pkg::*;
(
  input  logic [PS2_BYTE_W-1:0] code,
  output logic [PS2_BYTE_W-1:0] ascii
);

  // Plain lookup table; anything not listed is not a printable key.
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: pops bytes from the keyboard FIFO, strips the
// E0/F0 prefixes, tracks the held key and counts new presses.
// Optional feature: define PS2_ASCII_EN to register an ASCII translation of
// the held key on key_ascii; otherwise key_ascii is constant 0.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int COUNT_REPEAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PS2_BYTE_W-1:0] ps2_data,
  input  logic                  ps2_ready,
  input  logic                  ps2_overflow,
  output logic                  ps2_nextdata_n,
  output logic [PS2_BYTE_W-1:0] key_code,
  output logic                  key_ext,
  output logic                  key_held,
  output logic [PS2_BYTE_W-1:0] key_ascii,
  output logic                  make_pulse,
  output logic                  break_pulse,
  output logic [CNT_W-1:0]      press_cnt,
  output logic                  ovf_seen
);

  ps2_state_t state;
  logic       accept;
  logic       dec_make;
  logic       dec_brk;
  logic       dec_ext;
  logic       same_key;

  // A byte is taken only while no pop is in flight, so each byte is popped once.
  assign accept = ps2_ready && ps2_nextdata_n;

  // Classify the accepted byte given the prefix state; an overflow cycle discards it.
  always_comb begin
    dec_make = 1'b0;
    dec_brk  = 1'b0;
    dec_ext  = 1'b0;
    if (accept && !ps2_overflow) begin
      case (state)
        S_BASE: begin
          if (ps2_data != PS2_PFX_EXT && ps2_data != PS2_PFX_BRK) dec_make = 1'b1;
        end
        S_EXT: begin
          dec_ext = 1'b1;
          if (ps2_data != PS2_PFX_EXT && ps2_data != PS2_PFX_BRK) dec_make = 1'b1;
        end
        S_BRK: dec_brk = 1'b1;
        S_EXTBRK: begin
          dec_brk = 1'b1;
          dec_ext = 1'b1;
        end
        default: ;
      endcase
    end
    same_key = key_held && (key_code == ps2_data) && (key_ext == dec_ext);
  end

  // Prefix FSM, pop strobe, held-key tracking, pulses and press counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_BASE;
      ps2_nextdata_n <= 1'b1;
      key_code       <= '0;
      key_ext        <= 1'b0;
      key_held       <= 1'b0;
      make_pulse     <= 1'b0;
      break_pulse    <= 1'b0;
      press_cnt      <= '0;
      ovf_seen       <= 1'b0;
    end else begin
      ps2_nextdata_n <= !accept;
      make_pulse     <= 1'b0;
      break_pulse    <= 1'b0;
      ovf_seen       <= ovf_seen | ps2_overflow;

      if (ps2_overflow) begin
        state <= S_BASE;
      end else if (accept) begin
        case (state)
          S_BASE: begin
            if (ps2_data == PS2_PFX_EXT)      state <= S_EXT;
            else if (ps2_data == PS2_PFX_BRK) state <= S_BRK;
          end
          S_EXT: begin
            if (ps2_data == PS2_PFX_BRK)      state <= S_EXTBRK;
            else if (ps2_data != PS2_PFX_EXT) state <= S_BASE;
          end
          default: state <= S_BASE;
        endcase
      end

      if (dec_make) begin
        make_pulse <= 1'b1;
        if (same_key) begin
          if (COUNT_REPEAT != 0) press_cnt <= press_cnt + CNT_W'(1);
        end else begin
          key_code  <= ps2_data;
          key_ext   <= dec_ext;
          key_held  <= 1'b1;
          press_cnt <= press_cnt + CNT_W'(1);
        end
      end

      if (dec_brk && same_key) begin
        key_held    <= 1'b0;
        break_pulse <= 1'b1;
      end
    end
  end

`ifdef PS2_ASCII_EN
  logic [PS2_BYTE_W-1:0] rom_ascii;
  logic [PS2_BYTE_W-1:0] ascii_q;

  ps2_ascii_rom u_ascii_rom (
    .code  (ps2_data),
    .ascii (rom_ascii)
  );

  // Load the translation together with key_code; extended keys have no ASCII.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii_q <= '0;
    end else if (dec_make && !same_key) begin
      ascii_q <= dec_ext ? 8'h00 : rom_ascii;
    end
  end

  assign key_ascii = ascii_q;
`else
  assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: a queue models the keyboard
// FIFO, a table of byte groups drives the main decode paths, and hand-written
// sequences cover back-to-back pops, counter wrap, overflow and reset mid-pop.
module tb_ps2_scancode_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_held;
  logic [7:0] key_ascii;
  logic       make_pulse;
  logic       break_pulse;
  logic [7:0] press_cnt;
  logic       ovf_seen;

  ps2_scancode_decoder #(.CNT_W(8), .COUNT_REPEAT(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_data       (ps2_data),
    .ps2_ready      (ps2_ready),
    .ps2_overflow   (ps2_overflow),
    .ps2_nextdata_n (ps2_nextdata_n),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_held       (key_held),
    .key_ascii      (key_ascii),
    .make_pulse     (make_pulse),
    .break_pulse    (break_pulse),
    .press_cnt      (press_cnt),
    .ovf_seen       (ovf_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bytes;
    int          nbytes;
    logic [7:0]  code;
    logic        ext;
    logic        held;
    logic [7:0]  cnt;
    logic [7:0]  ascii;
    int          makes;
    int          breaks;
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] fifo[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         pops     = 0;
  int         makes    = 0;
  int         breaks   = 0;
  int         back2back = 0;
  logic       prev_nd  = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic void refreshFifo();
    ps2_ready = (fifo.size() != 0);
    ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endfunction

  // One clock step: at the falling edge, observe pulses and the pop strobe,
  // and pop the FIFO head as ps2_keyboard would.
  task automatic tick();
    @(negedge clk);
    if (!ps2_nextdata_n) begin
      pops++;
      if (!prev_nd) back2back++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    if (make_pulse)  makes++;
    if (break_pulse) breaks++;
    prev_nd = ps2_nextdata_n;
    refreshFifo();
  endtask

  task automatic applyStimulus(input logic [31:0] bytes, input int nbytes);
    int budget;
    for (int k = 0; k < nbytes; k++) fifo.push_back(bytes[31-8*k -: 8]);
    refreshFifo();
    budget = 0;
    while ((fifo.size() != 0 || !ps2_nextdata_n) && budget < 500) begin
      tick();
      budget++;
    end
    tick();
    if (budget >= 500) checkOutput("drain_timeout", 32'(budget), 32'd0);
  endtask

  function automatic logic [7:0] expAscii(input logic [7:0] a);
`ifdef PS2_ASCII_EN
    return a;
`else
    return (a == 8'hFF) ? 8'h00 : 8'h00;
`endif
  endfunction

  initial begin
    int budget;
    rst = 1'b1;
    ps2_overflow = 1'b0;
    refreshFifo();

    vecs[0]  = '{32'h1C000000, 1, 8'h1C, 1'b0, 1'b1, 8'd1, 8'h61, 1, 0};
    vecs[1]  = '{32'h1C1C0000, 2, 8'h1C, 1'b0, 1'b1, 8'd1, 8'h61, 2, 0};
    vecs[2]  = '{32'hF01C0000, 2, 8'h1C, 1'b0, 1'b0, 8'd1, 8'h61, 0, 1};
    vecs[3]  = '{32'hE0750000, 2, 8'h75, 1'b1, 1'b1, 8'd2, 8'h00, 1, 0};
    vecs[4]  = '{32'hE0F07500, 3, 8'h75, 1'b1, 1'b0, 8'd2, 8'h00, 0, 1};
    vecs[5]  = '{32'h1C000000, 1, 8'h1C, 1'b0, 1'b1, 8'd3, 8'h61, 1, 0};
    vecs[6]  = '{32'hF0320000, 2, 8'h1C, 1'b0, 1'b1, 8'd3, 8'h61, 0, 0};
    vecs[7]  = '{32'hE0000000, 1, 8'h1C, 1'b0, 1'b1, 8'd3, 8'h61, 0, 0};
    vecs[8]  = '{32'h1C000000, 1, 8'h1C, 1'b1, 1'b1, 8'd4, 8'h00, 1, 0};
    vecs[9]  = '{32'hF01C0000, 2, 8'h1C, 1'b1, 1'b1, 8'd4, 8'h00, 0, 0};
    vecs[10] = '{32'hE0F01C00, 3, 8'h1C, 1'b1, 1'b0, 8'd4, 8'h00, 0, 1};

    repeat (2) @(negedge clk);
    checkOutput("rst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
    checkOutput("rst_key_code",   32'(key_code),       32'd0);
    checkOutput("rst_key_held",   32'(key_held),       32'd0);
    checkOutput("rst_press_cnt",  32'(press_cnt),      32'd0);
    checkOutput("rst_pulses",     32'({make_pulse, break_pulse}), 32'd0);
    checkOutput("rst_ovf_seen",   32'(ovf_seen),       32'd0);
    rst = 1'b0;
    tick();

    // Table-driven decode rows, applied cumulatively.
    for (int i = 0; i < 11; i++) begin
      pops = 0; makes = 0; breaks = 0;
      applyStimulus(vecs[i].bytes, vecs[i].nbytes);
      checkOutput($sformatf("row%0d_code",  i), 32'(key_code),  32'(vecs[i].code));
      checkOutput($sformatf("row%0d_ext",   i), 32'(key_ext),   32'(vecs[i].ext));
      checkOutput($sformatf("row%0d_held",  i), 32'(key_held),  32'(vecs[i].held));
      checkOutput($sformatf("row%0d_cnt",   i), 32'(press_cnt), 32'(vecs[i].cnt));
      checkOutput($sformatf("row%0d_ascii", i), 32'(key_ascii), 32'(expAscii(vecs[i].ascii)));
      checkOutput($sformatf("row%0d_makes", i), 32'(makes),     32'(vecs[i].makes));
      checkOutput($sformatf("row%0d_breaks",i), 32'(breaks),    32'(vecs[i].breaks));
      checkOutput($sformatf("row%0d_pops",  i), 32'(pops),      32'(vecs[i].nbytes));
    end

    // Four bytes queued at once with ready held high.
    pops = 0; makes = 0; breaks = 0; back2back = 0;
    applyStimulus(32'h16F0161E, 4);
    checkOutput("burst_pops",      32'(pops),      32'd4);
    checkOutput("burst_back2back", 32'(back2back), 32'd0);
    checkOutput("burst_makes",     32'(makes),     32'd2);
    checkOutput("burst_breaks",    32'(breaks),    32'd1);
    checkOutput("burst_code",      32'(key_code),  32'h1E);
    checkOutput("burst_cnt",       32'(press_cnt), 32'd6);

    // Release 1E, then 250 press/release pairs take the counter 6 -> 256 = 0.
    applyStimulus(32'hF01E0000, 2);
    checkOutput("wrap_released", 32'(key_held), 32'd0);
    for (int n = 0; n < 249; n++) applyStimulus(32'h1CF01C00, 3);
    checkOutput("wrap_cnt_255", 32'(press_cnt), 32'd255);
    applyStimulus(32'h1CF01C00, 3);
    checkOutput("wrap_cnt_0",   32'(press_cnt), 32'd0);
    checkOutput("wrap_held",    32'(key_held),  32'd0);

    // Overflow drops a pending E0 prefix and is sticky.
    applyStimulus(32'hE0000000, 1);
    ps2_overflow = 1'b1;
    tick();
    ps2_overflow = 1'b0;
    applyStimulus(32'h1C000000, 1);
    checkOutput("ovf_seen",      32'(ovf_seen),  32'd1);
    checkOutput("ovf_ext_clear", 32'(key_ext),   32'd0);
    checkOutput("ovf_held",      32'(key_held),  32'd1);
    checkOutput("ovf_cnt",       32'(press_cnt), 32'd1);
    repeat (5) tick();
    checkOutput("ovf_sticky",    32'(ovf_seen),  32'd1);

    // Reset asserted while the pop strobe is low.
    applyStimulus(32'hF01C0000, 2);
    fifo.push_back(8'h32);
    refreshFifo();
    budget = 0;
    while (ps2_nextdata_n && budget < 20) begin
      tick();
      budget++;
    end
    checkOutput("midpop_reached", 32'(ps2_nextdata_n), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midpop_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
    checkOutput("midpop_key_code",   32'(key_code),       32'd0);
    checkOutput("midpop_key_held",   32'(key_held),       32'd0);
    checkOutput("midpop_press_cnt",  32'(press_cnt),      32'd0);
    checkOutput("midpop_ovf_seen",   32'(ovf_seen),       32'd0);
    checkOutput("midpop_pulses",     32'({make_pulse, break_pulse}), 32'd0);
    fifo.delete();
    refreshFifo();
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
